data_memory: RTL and testbench

Data-memory responder for the RV32I pipeline's MEM stage; it is the target the EX/MEM register drives with load/store requests. It accepts one request at a time through a valid/ready handshake and inserts a configurable number of wait states. It performs byte/half/word accesses with RV32I load sign/zero extension and returns read data plus an error flag. The pipeline stalls on `req_ready`/`rsp_valid`; storage is word-organised, little-endian, and is not cleared by reset.

---
 rtl/data_memory.sv | 173 +++++++++++++++++
 tb/tb_data_memory.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: RV32I MEM-stage data memory with a valid/ready request, configurable wait
// states and byte/half/word access. Optional define: DMEM_ALIGN_CHECK_EN (reject misaligned).
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        funct3_q;
  logic              op_we;
  logic [31:0]       op_addr, op_wdata;
  logic [2:0]        op_funct3;
  logic [1:0]        off_raw, off;
  logic              misalign, bad_funct3, out_of_range, op_err;
  logic [IDX_W-1:0]  op_idx;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data, rd_word, rd_shift, load_data;
  logic              accept, commit, mem_we;
  logic [31:0]       mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE) && !rst;

  // With WAIT_STATES = 0 the commit edge is also the accepting edge, so the access is
  // decoded from the live request in IDLE and from the captured copy otherwise.
  always_comb begin
    if (state == IDLE) begin
      op_we     = req_we;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
      op_funct3 = req_funct3;
    end else begin
      op_we     = we_q;
      op_addr   = addr_q;
      op_wdata  = wdata_q;
      op_funct3 = funct3_q;
    end
  end

  always_comb begin
    off_raw   = op_addr[1:0];
    off       = off_raw;
    byte_en   = 4'b1111;
    lane_data = op_wdata;
    case (op_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << off;
        lane_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        off[0]    = 1'b0;
        byte_en   = 4'b0011 << off;
        lane_data = {2{op_wdata[15:0]}};
      end
      default: off = 2'b00;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (off_raw != off);
`else
  assign misalign = 1'b0;
`endif

  assign bad_funct3   = op_we ? (op_funct3 > 3'd2)
                              : ((op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11));
  assign out_of_range = {2'b00, op_addr[31:2]} >= DEPTH_WORDS;
  assign op_err       = bad_funct3 || out_of_range || misalign;
  assign op_idx       = op_addr[IDX_W+1:2];
  assign rd_word      = mem[op_idx];
  assign rd_shift     = rd_word >> {off, 3'b000};

  always_comb begin
    case (op_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'h000000, rd_shift[7:0]};
      3'b101:  load_data = {16'h0000, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            accept = 1'b1;
            if (WAIT_STATES == 0) begin
              state_nxt = RESP;
              commit    = 1'b1;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end
        end
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mem_we = commit && op_we && !op_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enable) begin
      if (accept)                          cnt <= WAIT_INIT;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
      rsp_valid <= commit;
      if (commit) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? '0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      we_q     <= req_we;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[op_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random traffic against a
// byte-addressed reference model. Honours DMEM_ALIGN_CHECK_EN in the model.
module tb_data_memory;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        rst, enable, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  byte unsigned ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: byte array, size from funct3, extension by arithmetic.
  function automatic void ref_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, output bit err, output logic [31:0] rdata);
    int unsigned size;
    logic [31:0] a, v;
    err = 0; rdata = '0; a = addr;
    case (f3[1:0])
      2'b00: size = 1;
      2'b01: size = 2;
      2'b10: size = 4;
      default: size = 0;
    endcase
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) err = 1;
    if (size != 0 && (a % size) != 0) begin
`ifdef DMEM_ALIGN_CHECK_EN
      err = 1;
`else
      a = a - (a % size);
`endif
    end
    if (addr[31:2] >= DEPTH) err = 1;
    if (err) return;
    if (we) begin
      for (int unsigned i = 0; i < size; i++) ref_mem[a+i] = byte'(wdata >> (8*i));
    end else begin
      v = '0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (!f3[2] && size == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      rdata = v;
    end
  endfunction

  task automatic xact(input string tag, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input int hold, output logic [31:0] got);
    bit          eerr;
    logic [31:0] erd;
    int          k;
    ref_access(we, addr, wdata, f3, eerr, erd);
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(negedge clk);
    k = 1;
    while (!rsp_valid && k < 50) begin
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    check({tag, "/lat"}, k, WS + 1);
    check({tag, "/err"}, rsp_err, eerr);
    check({tag, "/rdata"}, rsp_rdata, erd);
    got = rsp_rdata;
    if (hold > 0) begin
      enable = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check({tag, "/hold"}, rsp_valid, 1'b1);
      end
      enable = 1'b1;
    end
    @(negedge clk);
    check({tag, "/pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, addr;
    bit          we;
    int          k;
    rst = 1'b1; enable = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(negedge clk);
    check("rst/ready", req_ready, 1'b0);
    check("rst/valid", rsp_valid, 1'b0);
    check("rst/rdata", rsp_rdata, 32'h0);
    check("rst/err", rsp_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/ready_after", req_ready, 1'b1);

    for (int w = 0; w < 64; w++) xact("init", 1'b1, 32'(w*4), $urandom, 3'b010, 0, got);
    xact("top/sw", 1'b1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 0, got);
    xact("top/lw", 1'b0, 32'hFFC, '0, 3'b010, 0, got);
    check("top/val", got, 32'hCAFE_F00D);

    xact("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, got);
    xact("lw10", 1'b0, 32'h10, '0, 3'b010, 0, got);
    check("lw10/val", got, 32'hDEAD_BEEF);
    xact("lb13", 1'b0, 32'h13, '0, 3'b000, 0, got);
    check("lb13/val", got, 32'hFFFF_FFDE);
    xact("lbu13", 1'b0, 32'h13, '0, 3'b100, 0, got);
    check("lbu13/val", got, 32'h0000_00DE);
    xact("lh10", 1'b0, 32'h10, '0, 3'b001, 0, got);
    check("lh10/val", got, 32'hFFFF_BEEF);
    xact("lhu12", 1'b0, 32'h12, '0, 3'b101, 0, got);
    check("lhu12/val", got, 32'h0000_DEAD);
    xact("sb11", 1'b1, 32'h11, 32'h0000_00AA, 3'b000, 0, got);
    xact("lw10b", 1'b0, 32'h10, '0, 3'b010, 0, got);
    check("lw10b/val", got, 32'hDEAD_AAEF);
    xact("lw_oor", 1'b0, 32'h1000, '0, 3'b010, 0, got);
    xact("sw_f3", 1'b1, 32'h10, 32'h1234_5678, 3'b011, 0, got);
    xact("lw10c", 1'b0, 32'h10, '0, 3'b010, 0, got);
    check("lw10c/val", got, 32'hDEAD_AAEF);
    xact("lw12", 1'b0, 32'h12, '0, 3'b010, 0, got);
    xact("hold3", 1'b0, 32'h10, '0, 3'b010, 3, got);

    // Reset during WAIT of a store: nothing committed, no response.
    xact("sw20", 1'b1, 32'h20, 32'h0BAD_C0DE, 3'b010, 0, got);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstw/ready", req_ready, 1'b0);
    check("rstw/valid", rsp_valid, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstw/novalid", rsp_valid, 1'b0);
    end
    xact("lw20", 1'b0, 32'h20, '0, 3'b010, 0, got);
    check("lw20/val", got, 32'h0BAD_C0DE);

    // Reset while the response is showing drops it.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    check("rstr/lat", k, WS + 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstr/valid", rsp_valid, 1'b0);
    check("rstr/rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rstr/ready", req_ready, 1'b1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom % 8)
        0: addr = 32'h1000 + ($urandom % 64);
        1: addr = $urandom | 32'h8000_0000;
        2: addr = 32'hFFC + ($urandom % 4);
        default: addr = $urandom % 256;
      endcase
      we = 1'($urandom);
      xact("rand", we, addr, $urandom, 3'($urandom), ($urandom % 8 == 0) ? 2 : 0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
